gpu_op_queue: RTL and testbench

- Command buffer directly upstream of the gpu rasteriser. Game/scene logic pushes packed 60-bit draw ops (gpu_op_t) into a FIFO.
- The block issues ops one at a time to the gpu. It pulses op_valid, holds the op stable for the whole draw, and retires the op on the gpu's single-cycle completion pulse.
- It also supports frame-level flush, reports busy status, counts retired ops, and latches a sticky protocol error.

---
 rtl/gpu_op_queue.sv | 133 +++++++++++++
 tb/tb_gpu_op_queue.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_op_queue.sv
// rtl/gpu_op_queue.sv - draw-op command FIFO that issues one op at a time to the gpu rasteriser
module gpu_op_queue #(
    parameter int DEPTH = 16,
    parameter int OP_W  = 60
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [OP_W-1:0] in_op,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [OP_W-1:0] gpu_op,
    output logic            gpu_op_valid,
    input  logic            gpu_op_done,
    input  logic            flush,
    output logic            busy,
    output logic [15:0]     ops_retired,
    output logic            err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY
    } state_t;

    logic [OP_W-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    state_t          state;
    logic            flush_pend;

    logic full;
    logic empty;
    logic push;
    logic retire;
    logic discard;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full && !flush_pend;
    assign push     = ce && in_valid && in_ready;
    assign retire   = ce && (state == BUSY) && gpu_op_done;
    // Idle flush drops everything now; an in-flight flush waits for the draw to retire.
    assign discard  = ce && (((state == IDLE) && flush) ||
                             (retire && (flush_pend || flush)));

    assign gpu_op = mem[rd_ptr];
    assign busy   = !empty || (state != IDLE);

    // Op storage; the head slot is never written while it is queued.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_op;
        end
    end

    // Pointer and occupancy bookkeeping; a discard also swallows a same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (discard) begin
                rd_ptr <= push ? (wr_ptr + 1'b1) : wr_ptr;
                count  <= '0;
            end else begin
                if (retire) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, retire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Issue FSM: one-cycle start pulse, wait for completion, retire, then one idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gpu_op_valid <= 1'b0;
            flush_pend   <= 1'b0;
            ops_retired  <= '0;
            err          <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (gpu_op_done) begin
                        err <= 1'b1;
                    end
                    if (!flush && !empty && !flush_pend) begin
                        gpu_op_valid <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    gpu_op_valid <= 1'b0;
                    state        <= BUSY;
                    if (gpu_op_done) begin
                        err <= 1'b1;
                    end
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                BUSY: begin
                    if (gpu_op_done) begin
                        ops_retired <= ops_retired + 1'b1;
                        flush_pend  <= 1'b0;
                        state       <= IDLE;
                    end else if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                default: begin
                    gpu_op_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_op_queue.sv
// tb/tb_gpu_op_queue.sv - self-checking bench for gpu_op_queue
module tb_gpu_op_queue;

    localparam int DEPTH = 16;
    localparam int OP_W  = 60;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ce = 1'b1;
    logic [OP_W-1:0] in_op = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [OP_W-1:0] gpu_op;
    logic            gpu_op_valid;
    logic            gpu_op_done = 1'b0;
    logic            flush = 1'b0;
    logic            busy;
    logic [15:0]     ops_retired;
    logic            err;

    gpu_op_queue #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .in_op       (in_op),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .gpu_op      (gpu_op),
        .gpu_op_valid(gpu_op_valid),
        .gpu_op_done (gpu_op_done),
        .flush       (flush),
        .busy        (busy),
        .ops_retired (ops_retired),
        .err         (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [OP_W-1:0] mk_op(input logic [15:0] x);
        return {28'h5A5A5A5, ~x, x};
    endfunction

    // Reference model: a queue of not-yet-retired ops plus draw/pulse/flush-pending flags.
    logic [OP_W-1:0] mq[$];
    bit              m_draw = 0;
    bit              m_pulse = 0;
    bit              m_fpend = 0;
    bit              m_err = 0;
    logic [15:0]     m_ret = '0;
    int              n0;
    bit              acc;
    int              cyc = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_draw = 0; m_pulse = 0; m_fpend = 0; m_err = 0; m_ret = '0;
        end else begin
            cyc++;
            if (ce) begin
                n0  = mq.size();
                acc = in_valid && (n0 < DEPTH) && !m_fpend;
                if (acc) mq.push_back(in_op);
                if (!m_draw) begin
                    if (gpu_op_done) m_err = 1;
                    if (flush) mq.delete();
                    else if (n0 > 0) begin
                        m_draw  = 1;
                        m_pulse = 1;
                    end
                end else if (m_pulse) begin
                    if (gpu_op_done) m_err = 1;
                    if (flush) m_fpend = 1;
                    m_pulse = 0;
                end else if (gpu_op_done) begin
                    void'(mq.pop_front());
                    m_ret++;
                    m_draw = 0;
                    if (m_fpend || flush) begin
                        mq.delete();
                        m_fpend = 0;
                    end
                end else if (flush) begin
                    m_fpend = 1;
                end
            end
        end
    end

    // Gpu stand-in: raises done gpu_lat ce-cycles after a start pulse, for one ce-cycle.
    bit gpu_auto = 0;
    int gpu_lat = 5;
    int gpu_cnt = 0;
    bit ce_edge;

    initial forever begin
        @(posedge clk);
        ce_edge = ce;
        #2;
        if (gpu_auto && ce_edge && !rst) begin
            if (gpu_op_done) gpu_op_done = 1'b0;
            if (gpu_cnt > 0) begin
                gpu_cnt--;
                if (gpu_cnt == 0) gpu_op_done = 1'b1;
            end else if (gpu_op_valid) begin
                gpu_cnt = gpu_lat;
            end
        end
    end

    bit ce_toggle = 0;
    initial forever begin
        @(posedge clk);
        #1;
        ce = ce_toggle ? !ce : 1'b1;
    end

    // Per-cycle comparison against the model, plus issue-order and pulse-width records.
    logic [15:0] iss[$];
    int          st_t[$];
    bit          prev_v = 0;
    int          pulse_ce_edges = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("in_ready", in_ready, (mq.size() < DEPTH) && !m_fpend);
            check("busy", busy, (mq.size() > 0) || m_draw);
            check("gpu_op_valid", gpu_op_valid, m_pulse);
            check("err", err, m_err);
            check("ops_retired", ops_retired, m_ret);
            if (m_draw) check("gpu_op", gpu_op, mq[0]);
            if (gpu_op_valid && ce) pulse_ce_edges++;
            if (gpu_op_valid && !prev_v) begin
                iss.push_back(gpu_op[15:0]);
                st_t.push_back(cyc);
            end
            prev_v = gpu_op_valid;
        end else begin
            prev_v = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [15:0] x);
        bit ok;
        ok = 0;
        in_op = mk_op(x);
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = ce && in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL push_timeout: op %0d not accepted, want accepted", x);
        end
    endtask

    task automatic done_pulse();
        gpu_op_done = 1'b1;
        step();
        gpu_op_done = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        step();
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy=%0d, want 0", busy);
        end
    endtask

    task automatic check_now(input string name, input logic [63:0] act, input logic [63:0] exp);
        @(negedge clk);
        check(name, act, exp);
        step();
    endtask

    initial begin
        // Reset state
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", gpu_op_valid, 0);
        check("rst_retired", ops_retired, 0);
        check("rst_err", err, 0);
        step();

        // Three ops, done 5 cycles after each start
        gpu_auto = 1; gpu_lat = 5; iss.delete();
        push(16'd0); push(16'd10); push(16'd20);
        wait_idle();
        check("t1_retired", ops_retired, 3);
        check("t1_err", err, 0);
        check("t1_nissued", iss.size(), 3);
        if (iss.size() == 3) begin
            check("t1_order0", iss[0], 0);
            check("t1_order1", iss[1], 10);
            check("t1_order2", iss[2], 20);
        end

        // Fill to DEPTH with a stalled gpu
        gpu_auto = 0; iss.delete();
        for (int i = 0; i < DEPTH; i++) push(16'(100 + i));
        check_now("t2_full_ready", in_ready, 0);
        in_op = mk_op(16'd999); in_valid = 1'b1;
        @(negedge clk);
        check("t2_17th_ready", in_ready, 0);
        step();
        in_valid = 1'b0;
        done_pulse();
        @(negedge clk);
        check("t2_ready_after_done", in_ready, 1);
        check("t2_head", gpu_op[15:0], 101);
        step();
        gpu_auto = 1; gpu_lat = 1;
        wait_idle();
        check("t2_retired", ops_retired, 19);
        check("t2_nissued", iss.size(), 16);

        // Short op: back-to-back start spacing
        gpu_lat = 2; iss.delete(); st_t.delete();
        push(16'd50); push(16'd51);
        wait_idle();
        check("t3_retired", ops_retired, 21);
        check("t3_nstarts", st_t.size(), 2);
        if (st_t.size() == 2) check("t3_spacing", st_t[1] - st_t[0], 4);

        // Flush with the first op in flight
        gpu_auto = 0; iss.delete();
        for (int i = 0; i < 5; i++) push(16'(200 + i));
        idle(3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_now("t4_ready_pend", in_ready, 0);
        in_op = mk_op(16'd300); in_valid = 1'b1;
        idle(2);
        in_valid = 1'b0;
        done_pulse();
        idle(4);
        check("t4_busy", busy, 0);
        check("t4_retired", ops_retired, 22);
        check("t4_nissued", iss.size(), 1);

        // Spurious done while idle sets sticky err
        idle(2);
        done_pulse();
        check_now("t5_err_set", err, 1);
        idle(5);
        check_now("t5_err_sticky", err, 1);
        gpu_auto = 1; gpu_lat = 3;
        push(16'd400); push(16'd401);
        wait_idle();
        check("t5_retired", ops_retired, 24);
        check("t5_err_kept", err, 1);
        rst = 1'b1;
        #2;
        check("t5_async_err", err, 0);
        check("t5_async_retired", ops_retired, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Alternating clock enable
        ce_toggle = 1; iss.delete(); pulse_ce_edges = 0; gpu_lat = 3;
        for (int i = 0; i < 4; i++) push(16'(500 + i));
        wait_idle();
        check("t6_retired", ops_retired, 4);
        check("t6_pulse_width", pulse_ce_edges, 4);
        check("t6_nissued", iss.size(), 4);
        if (iss.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t6_order", iss[i], 500 + i);
        end
        ce_toggle = 0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
